ctrl_seq_tracker: RTL and testbench
===================================

# ctrl_seq_tracker

Passive observer for the control-sequencer outputs. It watches the four control strobes `tclk`, `trst`, `dq_en` and `sr_en`, and recovers the 40-cycle frame phase from them, reversing the count-to-strobe decode done by the sequencer FSM. It declares lock after clean frames and flags any strobe that deviates from the frame schedule. It sits beside the sequencer in the same clock domain, and its output is consumed by the formal and simulation benches and by the debug status registers.

## Interface
- `FRAME_LEN`, 40, cycles per frame; the recovered phase counts 0..FRAME_LEN-1.
- `LOCK_FRAMES`, 1, consecutive clean complete frames needed in SYNC before `locked` asserts; must be ≥1.
- `CNT_W`, 16, width of the saturating `frame_cnt` and `err_cnt`.

Ports:
- `clk`  in  1  sole clock; all logic rising-edge.
- `rst`  in  1  synchronous, active-high reset.
- `tclk`  in  1  observed test clock strobe.
- `trst`  in  1  observed reset strobe; its rising edge marks phase 0.
- `dq_en`  in  1  observed DQ enable.
- `sr_en`  in  1  observed shift-register enable.
- `phase`  out  6  recovered count for the sample taken the previous cycle.
- `phase_vld`  out  1  `phase` is meaningful (state SYNC or LOCKED).
- `locked`  out  1  tracker is in LOCKED.
- `err`  out  1  one-cycle pulse on a schedule mismatch.
- `err_code`  out  4  mismatch mask {sr_en,dq_en,tclk,trst}; held until the next `err`.
- `frame_cnt`  out  CNT_W  clean frames completed while LOCKED; saturating.
- `err_cnt`  out  CNT_W  total `err` pulses; saturating.

## Operation
- The expected strobes `exp(ph)` are a pure function of phase `ph`:
  - `trst` is high for ph 0–1.
  - `tclk` is high for ph 5–9, 15–19, 25–29 and 35–39.
  - `dq_en` is high for ph 2–17.
  - `sr_en` is high for ph 20–37.
  - Each strobe is low everywhere else.
- The state register holds `trst_q`, the previous-cycle `trst`. Its reset value is 1, so a `trst` held high through reset is not an edge.
- **HUNT**:
  - On a sample with `trst`=1 and `trst_q`=0, set ph ← 1 and go to SYNC. The edge sample is treated as ph 0 and checked against `exp(0)`.
  - If that check fails, `err` fires and the state stays in HUNT.
- **SYNC**:
  - Each sample is compared with `exp(ph)`.
  - ph wraps from FRAME_LEN-1 to 0.
  - A clean sample at ph=FRAME_LEN-1 increments the internal clean-frame count. When that count reaches LOCK_FRAMES, go to LOCKED.
- **LOCKED**:
  - Each sample is compared with `exp(ph)`.
  - A clean sample at ph=FRAME_LEN-1 increments `frame_cnt`.
- **Any mismatch in SYNC or LOCKED**:
  - `err` pulses and `err_code` is set to the XOR of the sampled strobes with `exp(ph)`.
  - `err_cnt` increments and the internal clean-frame count clears.
  - The state goes to HUNT.
  - A `trst` rising edge on the erroring sample is not used to re-acquire. The next edge is required.
- Saturation: `frame_cnt` and `err_cnt` stop at 2^CNT_W-1 and do not wrap.
- Reset values: state HUNT, ph 0, `trst_q` 1, and every output 0.

## Timing
- All outputs are registered with 1-cycle latency. The response to the sample at cycle t is visible at t+1.
- With the `trst` edge at cycle t:
  - `phase_vld`=1 and `phase`=0 at t+1.
  - `phase`=k at t+1+k.
  - With LOCK_FRAMES=1, `locked` rises at t+40.
- `err` is high for exactly one cycle per mismatch.
- `locked` and `phase_vld` fall in the same cycle that `err` rises.
- `rst` asserted mid-operation returns everything to reset values on the next edge, regardless of state.

## Structure
- Package `ctrl_seq_pkg` holds:
  - the `FRAME_LEN` default;
  - the strobe window constants;
  - the state enum {HUNT, SYNC, LOCKED};
  - the `err_code` bit indices;
  - the function `ctrl_seq_exp(ph)` returning the 4-bit expected vector. The sequencer bench assertions reuse this function.
- One sub-module, `ctrl_seq_sat_cnt` (parameter width, with inc and clear, saturating), is instantiated for `frame_cnt`, `err_cnt` and the internal clean-frame count.

## Test plan
- Clean stream from a reference 0..39 counter with `trst` edge at cycle 10 → `phase_vld` at 11, `phase` follows count−1 lag, `locked` at 50, `frame_cnt`=3 after three further frames, `err` never asserts.
- After lock, force `dq_en`=0 at ph 5 → `err`=1 for one cycle, `err_code`=4'b0100, `locked`=0 on the same cycle, `err_cnt`=1, re-lock 40 cycles after the next `trst` edge.
- `trst` held high through reset and after release → no edge, state stays HUNT and `phase_vld`=0 until `trst` falls and rises again.
- All strobes stuck low for 200 cycles → never leaves HUNT, `err_cnt`=0.
- With LOCK_FRAMES=2 and CNT_W=2, inject repeated errors → lock only after two clean frames, and `err_cnt` saturates at 3.
- `rst` asserted at ph 20 while LOCKED → all outputs 0 on the next cycle, and re-acquisition happens on the following `trst` edge.

Source files
------------

// File: rtl/ctrl_seq_pkg.sv
// ctrl_seq_tracker shared definitions.
// Frame schedule, state encoding and expected-strobe decode.
package ctrl_seq_pkg;

    localparam int FRAME_LEN_DEF = 40;
    localparam int PH_W          = 6;

    // strobe windows, inclusive phase bounds
    localparam int TRST_LO     = 0;
    localparam int TRST_HI     = 1;
    localparam int TCLK_PERIOD = 10;
    localparam int TCLK_OFS    = 5;
    localparam int DQ_LO       = 2;
    localparam int DQ_HI       = 17;
    localparam int SR_LO       = 20;
    localparam int SR_HI       = 37;

    // err_code / strobe vector bit positions
    localparam int TRST_BIT = 0;
    localparam int TCLK_BIT = 1;
    localparam int DQ_BIT   = 2;
    localparam int SR_BIT   = 3;

    typedef enum logic [1:0] {
        HUNT   = 2'd0,
        SYNC   = 2'd1,
        LOCKED = 2'd2
    } state_e;

    // Expected {sr_en,dq_en,tclk,trst} for a given phase.
    function automatic logic [3:0] ctrl_seq_exp(input logic [PH_W-1:0] ph);
        int         p;
        logic [3:0] v;
        p           = int'(ph);
        v           = '0;
        v[TRST_BIT] = (p >= TRST_LO) && (p <= TRST_HI);
        v[TCLK_BIT] = (p % TCLK_PERIOD) >= TCLK_OFS;
        v[DQ_BIT]   = (p >= DQ_LO) && (p <= DQ_HI);
        v[SR_BIT]   = (p >= SR_LO) && (p <= SR_HI);
        return v;
    endfunction

endpackage

// File: rtl/ctrl_seq_tracker_sat_cnt.sv
// Saturating up-counter with synchronous clear.
// Clear wins over increment; holds at all-ones.
module ctrl_seq_sat_cnt #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr_i,
    input  logic         inc_i,
    output logic [W-1:0] cnt_o
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    // next count: clear, saturating increment, or hold
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    // count register
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/ctrl_seq_tracker.sv
// Passive frame-phase tracker for the control sequencer strobes.
// Acquires on a trst rising edge, locks after clean frames, flags deviations.
module ctrl_seq_tracker
    import ctrl_seq_pkg::*;
#(
    parameter int FRAME_LEN   = FRAME_LEN_DEF,
    parameter int LOCK_FRAMES = 1,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tclk,
    input  logic             trst,
    input  logic             dq_en,
    input  logic             sr_en,
    output logic [5:0]       phase,
    output logic             phase_vld,
    output logic             locked,
    output logic             err,
    output logic [3:0]       err_code,
    output logic [CNT_W-1:0] frame_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int CLEAN_W = (LOCK_FRAMES < 1) ? 1 : $clog2(LOCK_FRAMES + 1);

    state_e            state_q, state_d;
    logic [PH_W-1:0]   ph_q, ph_d;
    logic              trst_q;
    logic [PH_W-1:0]   phase_q, phase_d;
    logic              vld_q, vld_d;
    logic              locked_q, locked_d;
    logic              err_q, err_d;
    logic [3:0]        code_q, code_d;

    logic [3:0]        obs;
    logic [3:0]        mism;
    logic [PH_W-1:0]   ph_cur;
    logic [PH_W-1:0]   ph_nxt;
    logic              edge_det;
    logic              last;
    logic              err_inc;
    logic              frame_inc;
    logic              clean_inc;
    logic              clean_clr;
    logic [CLEAN_W-1:0] clean_cnt;

    // sample compare against the schedule and next-state selection
    always_comb begin
        obs           = '0;
        obs[TRST_BIT] = trst;
        obs[TCLK_BIT] = tclk;
        obs[DQ_BIT]   = dq_en;
        obs[SR_BIT]   = sr_en;
        edge_det      = trst & ~trst_q;
        ph_cur        = (state_q == HUNT) ? '0 : ph_q;
        mism          = obs ^ ctrl_seq_exp(ph_cur);
        last          = (ph_cur == PH_W'(FRAME_LEN - 1));
        ph_nxt        = last ? '0 : ph_cur + PH_W'(1);

        state_d   = state_q;
        ph_d      = ph_q;
        phase_d   = '0;
        vld_d     = 1'b0;
        locked_d  = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        err_inc   = 1'b0;
        frame_inc = 1'b0;
        clean_inc = 1'b0;
        clean_clr = 1'b0;

        unique case (state_q)
            HUNT: begin
                if (edge_det) begin
                    if (mism != '0) begin
                        err_d     = 1'b1;
                        code_d    = mism;
                        err_inc   = 1'b1;
                        clean_clr = 1'b1;
                    end else begin
                        state_d = SYNC;
                        ph_d    = ph_nxt;
                        phase_d = ph_cur;
                        vld_d   = 1'b1;
                    end
                end
            end
            SYNC, LOCKED: begin
                if (mism != '0) begin
                    state_d   = HUNT;
                    ph_d      = '0;
                    err_d     = 1'b1;
                    code_d    = mism;
                    err_inc   = 1'b1;
                    clean_clr = 1'b1;
                end else begin
                    ph_d     = ph_nxt;
                    phase_d  = ph_cur;
                    vld_d    = 1'b1;
                    locked_d = (state_q == LOCKED);
                    if (last && (state_q == LOCKED)) begin
                        frame_inc = 1'b1;
                    end
                    if (last && (state_q == SYNC)) begin
                        if (clean_cnt == CLEAN_W'(LOCK_FRAMES - 1)) begin
                            state_d   = LOCKED;
                            locked_d  = 1'b1;
                            clean_clr = 1'b1;
                        end else begin
                            clean_inc = 1'b1;
                        end
                    end
                end
            end
            default: begin
                state_d = HUNT;
                ph_d    = '0;
            end
        endcase
    end

    // state and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= HUNT;
            ph_q     <= '0;
            trst_q   <= 1'b1;
            phase_q  <= '0;
            vld_q    <= 1'b0;
            locked_q <= 1'b0;
            err_q    <= 1'b0;
            code_q   <= '0;
        end else begin
            state_q  <= state_d;
            ph_q     <= ph_d;
            trst_q   <= trst;
            phase_q  <= phase_d;
            vld_q    <= vld_d;
            locked_q <= locked_d;
            err_q    <= err_d;
            code_q   <= code_d;
        end
    end

    ctrl_seq_sat_cnt #(.W(CNT_W)) u_frame_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (frame_inc),
        .cnt_o (frame_cnt)
    );

    ctrl_seq_sat_cnt #(.W(CNT_W)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (1'b0),
        .inc_i (err_inc),
        .cnt_o (err_cnt)
    );

    ctrl_seq_sat_cnt #(.W(CLEAN_W)) u_clean_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr_i (clean_clr),
        .inc_i (clean_inc),
        .cnt_o (clean_cnt)
    );

    assign phase     = phase_q;
    assign phase_vld = vld_q;
    assign locked    = locked_q;
    assign err       = err_q;
    assign err_code  = code_q;

endmodule

// File: tb/tb_ctrl_seq_tracker.sv
// Directed bench for ctrl_seq_tracker.
// Second instance covers LOCK_FRAMES=2 with 2-bit counters.
module tb_ctrl_seq_tracker;

    logic        clk;
    logic        rst;
    logic        tclk;
    logic        trst;
    logic        dq_en;
    logic        sr_en;

    logic [5:0]  phase;
    logic        phase_vld;
    logic        locked;
    logic        err;
    logic [3:0]  err_code;
    logic [15:0] frame_cnt;
    logic [15:0] err_cnt;

    logic [5:0]  phase2;
    logic        phase_vld2;
    logic        locked2;
    logic        err2;
    logic [3:0]  err_code2;
    logic [1:0]  frame_cnt2;
    logic [1:0]  err_cnt2;

    int checks;
    int failures;
    int seen;

    ctrl_seq_tracker dut (
        .clk       (clk),
        .rst       (rst),
        .tclk      (tclk),
        .trst      (trst),
        .dq_en     (dq_en),
        .sr_en     (sr_en),
        .phase     (phase),
        .phase_vld (phase_vld),
        .locked    (locked),
        .err       (err),
        .err_code  (err_code),
        .frame_cnt (frame_cnt),
        .err_cnt   (err_cnt)
    );

    ctrl_seq_tracker #(
        .LOCK_FRAMES (2),
        .CNT_W       (2)
    ) dut2 (
        .clk       (clk),
        .rst       (rst),
        .tclk      (tclk),
        .trst      (trst),
        .dq_en     (dq_en),
        .sr_en     (sr_en),
        .phase     (phase2),
        .phase_vld (phase_vld2),
        .locked    (locked2),
        .err       (err2),
        .err_code  (err_code2),
        .frame_cnt (frame_cnt2),
        .err_cnt   (err_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // hand-written frame schedule {sr_en,dq_en,tclk,trst}
    function automatic logic [3:0] tb_exp(input int k);
        logic t, c, d, s;
        t = (k <= 1);
        c = (k >= 5 && k <= 9) || (k >= 15 && k <= 19) ||
            (k >= 25 && k <= 29) || (k >= 35 && k <= 39);
        d = (k >= 2 && k <= 17);
        s = (k >= 20 && k <= 37);
        return {s, d, c, t};
    endfunction

    task automatic drive(input logic [3:0] v);
        {sr_en, dq_en, tclk, trst} = v;
        @(posedge clk);
        #1;
    endtask

    task automatic ph_tick(input int k);
        drive(tb_exp(k));
    endtask

    // one clean frame from phase 0, phase tracked on dut every cycle
    task automatic clean_frame(input string tag);
        for (int k = 0; k < 40; k++) begin
            ph_tick(k);
            chk({tag, "_phase"}, 32'(phase), 32'(k));
            if (err || err2) seen++;
            if (k == 0) chk({tag, "_vld0"}, 32'(phase_vld), 32'd1);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        seen     = 0;
        rst      = 1'b1;
        {sr_en, dq_en, tclk, trst} = 4'b0001;

        // reset with trst held high
        for (int i = 0; i < 3; i++) drive(4'b0001);
        chk("rst_phase", 32'(phase), 32'd0);
        chk("rst_vld", 32'(phase_vld), 32'd0);
        chk("rst_locked", 32'(locked), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_code", 32'(err_code), 32'd0);
        chk("rst_fcnt", 32'(frame_cnt), 32'd0);
        chk("rst_ecnt", 32'(err_cnt), 32'd0);

        // trst still high after release: no edge
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            drive(4'b0001);
            if (phase_vld) seen++;
        end
        chk("held_trst_vld", 32'(seen), 32'd0);

        // all strobes stuck low
        seen = 0;
        for (int i = 0; i < 200; i++) begin
            drive(4'b0000);
            if (phase_vld || err) seen++;
        end
        chk("stuck_hunt", 32'(seen), 32'd0);
        chk("stuck_ecnt", 32'(err_cnt), 32'd0);

        // acquisition frame: lock on the last sample
        seen = 0;
        for (int k = 0; k < 40; k++) begin
            ph_tick(k);
            if (phase !== 6'(k) || !phase_vld) seen++;
            if (k == 0) chk("acq_vld", 32'(phase_vld), 32'd1);
            if (k == 38) chk("acq_unlock38", 32'(locked), 32'd0);
            if (k == 39) chk("acq_lock39", 32'(locked), 32'd1);
            if (err) seen++;
        end
        chk("acq_track", 32'(seen), 32'd0);

        // three locked frames
        seen = 0;
        for (int f = 0; f < 3; f++) clean_frame("run");
        chk("run_noerr", 32'(seen), 32'd0);
        chk("run_fcnt", 32'(frame_cnt), 32'd3);
        chk("run_locked2", 32'(locked2), 32'd1);
        chk("run_fcnt2", 32'(frame_cnt2), 32'd2);

        // dq_en dropped at phase 5
        for (int k = 0; k < 5; k++) ph_tick(k);
        drive(tb_exp(5) & ~4'b0100);
        chk("dq_err", 32'(err), 32'd1);
        chk("dq_code", 32'(err_code), 32'h4);
        chk("dq_locked", 32'(locked), 32'd0);
        chk("dq_vld", 32'(phase_vld), 32'd0);
        chk("dq_ecnt", 32'(err_cnt), 32'd1);
        ph_tick(6);
        chk("dq_err_pulse", 32'(err), 32'd0);
        chk("dq_code_hold", 32'(err_code), 32'h4);
        for (int k = 7; k < 40; k++) ph_tick(k);
        chk("dq_hunt_vld", 32'(phase_vld), 32'd0);
        for (int k = 0; k < 40; k++) begin
            ph_tick(k);
            if (k == 38) chk("relock38", 32'(locked), 32'd0);
            if (k == 39) chk("relock39", 32'(locked), 32'd1);
        end
        chk("relock_fcnt", 32'(frame_cnt), 32'd3);

        // reset at phase 20 while locked
        for (int k = 0; k < 20; k++) ph_tick(k);
        rst = 1'b1;
        ph_tick(20);
        rst = 1'b0;
        chk("mrst_locked", 32'(locked), 32'd0);
        chk("mrst_vld", 32'(phase_vld), 32'd0);
        chk("mrst_phase", 32'(phase), 32'd0);
        chk("mrst_code", 32'(err_code), 32'd0);
        chk("mrst_fcnt", 32'(frame_cnt), 32'd0);
        chk("mrst_ecnt", 32'(err_cnt), 32'd0);
        chk("mrst_locked2", 32'(locked2), 32'd0);
        seen = 0;
        for (int k = 21; k < 40; k++) begin
            ph_tick(k);
            if (phase_vld) seen++;
        end
        chk("mrst_hunt", 32'(seen), 32'd0);
        seen = 0;
        clean_frame("reacq");
        chk("reacq_locked", 32'(locked), 32'd1);
        chk("reacq_locked2_1", 32'(locked2), 32'd0);
        clean_frame("reacq2");
        chk("reacq_locked2_2", 32'(locked2), 32'd1);
        chk("reacq_noerr", 32'(seen), 32'd0);

        // error train: saturate the 2-bit counter
        drive(4'b0000);
        chk("tr_err1", 32'(err), 32'd1);
        chk("tr_code1", 32'(err_code), 32'h1);
        chk("tr_err2_1", 32'(err2), 32'd1);
        for (int i = 0; i < 3; i++) begin
            drive(4'b0001);
            chk("tr_pulse", 32'(err), 32'd0);
            chk("tr_sync_vld", 32'(phase_vld), 32'd1);
            drive(4'b0000);
            chk("tr_err", 32'(err2), 32'd1);
        end
        chk("tr_ecnt", 32'(err_cnt), 32'd4);
        chk("tr_ecnt2_sat", 32'(err_cnt2), 32'd3);

        // two clean frames needed for the second instance
        clean_frame("lk2a");
        chk("lk2_locked", 32'(locked), 32'd1);
        chk("lk2_a", 32'(locked2), 32'd0);
        clean_frame("lk2b");
        chk("lk2_b", 32'(locked2), 32'd1);
        chk("lk2_ecnt2_sat", 32'(err_cnt2), 32'd3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
